// File: rtl/ucr_pkg.sv
// Shared definitions for the universal up/down counter family.
// Other counter users import the function-select enum from here.
package ucr_pkg;

  typedef enum logic [0:1] {
    UCR_LOAD = 2'b00,
    UCR_DEC  = 2'b01,
    UCR_INC  = 2'b10,
    UCR_HOLD = 2'b11
  } ucr_sel_t;

  localparam int UCR_BCD_MODULUS = 10;

endpackage

// File: rtl/universal_counter_n_if.sv
// Control/data bundle for one universal_counter_n stage.
// The master drives function and data; the slave is the counter.
interface universal_counter_n_if
  import ucr_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic [0:WIDTH-1] D;
  logic             CIN;
  ucr_sel_t         SEL;
  logic             CLR;
  logic [0:WIDTH-1] Q;
  logic             COUT;
  logic             TC;

  modport master (
    output D, CIN, SEL, CLR,
    input  Q, COUT, TC
  );

  modport slave (
    input  D, CIN, SEL, CLR,
    output Q, COUT, TC
  );
endinterface

// File: rtl/universal_counter_n.sv
// Parametrised binary/modulo-N up/down counter with load, clear, registered
// wrap pulse (COUT) and combinational terminal count (TC) for cascading.
module universal_counter_n
  import ucr_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = longint'(1) << WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET,
  universal_counter_n_if.slave bus
);

  localparam logic [WIDTH:0] MOD_M1 = (WIDTH+1)'(MODULUS - 64'd1);

  logic [0:WIDTH-1] q_r;
  logic             cout_r;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH-1:0] inc_q;
  logic [WIDTH-1:0] dec_q;
  logic [WIDTH-1:0] top_q;
  logic             at_top;
  logic             at_zero;

  // Extra headroom bit keeps the top-of-range compare correct for any
  // out-of-range value placed by LOAD.
  assign q_ext   = {1'b0, q_r};
  assign inc_q   = WIDTH'(q_ext + (WIDTH+1)'(1));
  assign dec_q   = WIDTH'(q_ext - (WIDTH+1)'(1));
  assign top_q   = WIDTH'(MOD_M1);
  assign at_top  = (q_ext >= MOD_M1);
  assign at_zero = (q_r == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_r    <= '0;
      cout_r <= 1'b0;
    end else if (bus.CLR) begin
      q_r    <= '0;
      cout_r <= 1'b0;
    end else begin
      cout_r <= 1'b0;
      case (bus.SEL)
        UCR_LOAD: q_r <= bus.D;
        UCR_INC: begin
          if (bus.CIN) begin
            if (at_top) begin
              q_r    <= '0;
              cout_r <= 1'b1;
            end else begin
              q_r <= inc_q;
            end
          end
        end
        UCR_DEC: begin
          if (bus.CIN) begin
            if (at_zero) begin
              q_r    <= top_q;
              cout_r <= 1'b1;
            end else begin
              q_r <= dec_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // TC looks ahead at this cycle's wrap so a following stage can use it as
  // its CIN on the same edge.
  assign bus.TC = bus.CIN & ~bus.CLR &
                  (((bus.SEL == UCR_INC) & at_top) |
                   ((bus.SEL == UCR_DEC) & at_zero));

  assign bus.Q    = q_r;
  assign bus.COUT = cout_r;

endmodule
